mem_arbiter: RTL and testbench

- Arbiter directly downstream of the instruction cache and data cache; single-core.
- Takes the icache refill request (iREN/iaddr) and the dcache request (dREN/dWEN/daddr/dstore).
- Grants one request at a time to the single-ported RAM and returns the load data and wait signals to the caches.
- Holds each grant until the RAM completes the access; a starvation counter bounds how long instruction fetch waits behind data traffic.

---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-core memory arbiter between icache/dcache and a single-ported RAM.
// One grant at a time; a starvation counter forces an instruction grant after STARVE_MAX data grants.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IGRANT  = 3'd1,
    DREAD   = 3'd2,
    DWRITE  = 3'd3,
    ERRWAIT = 3'd4
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state_q, state_d;
  logic [3:0] starve_q, starve_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    iwait    = 1'b1;
    iload    = '0;
    dwait    = 1'b1;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    memerr   = 1'b0;

    case (state_q)
      IDLE: begin
        if (iREN && (starve_q == STARVE_LIM)) state_d = IGRANT;
        else if (dWEN)                        state_d = DWRITE;
        else if (dREN)                        state_d = DREAD;
        else if (iREN)                        state_d = IGRANT;
      end

      IGRANT: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == RAM_ACCESS) begin
            iwait    = 1'b0;
            iload    = ramload;
            state_d  = IDLE;
            starve_d = '0;
          end else if (ramstate == RAM_ERROR) begin
            memerr  = 1'b1;
            state_d = ERRWAIT;
          end
        end
      end

      DREAD: begin
        if (!dREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = daddr;
          if (ramstate == RAM_ACCESS) begin
            dwait   = 1'b0;
            dload   = ramload;
            state_d = IDLE;
            if (iREN && (starve_q != STARVE_LIM)) starve_d = starve_q + 4'd1;
          end else if (ramstate == RAM_ERROR) begin
            memerr  = 1'b1;
            state_d = ERRWAIT;
          end
        end
      end

      DWRITE: begin
        if (!dWEN) begin
          state_d = IDLE;
        end else begin
          ramWEN   = 1'b1;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ramstate == RAM_ACCESS) begin
            dwait   = 1'b0;
            state_d = IDLE;
            if (iREN && (starve_q != STARVE_LIM)) starve_d = starve_q + 4'd1;
          end else if (ramstate == RAM_ERROR) begin
            memerr  = 1'b1;
            state_d = ERRWAIT;
          end
        end
      end

      // One dead cycle with enables low before re-arbitrating the same request.
      ERRWAIT: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    if (!iREN) starve_d = '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single grants, starvation order, error retry, withdrawal.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        memerr;

  int passed = 0;
  int total  = 0;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller sets inputs just after a falling edge, then calls this; each grant
  // is expected to be preceded by one IDLE cycle and to complete in one cycle.
  task automatic grants(input int n, input logic [15:0] imask, input string tag);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge CLK);
      #1;
      chk({tag, "_idle_ren"}, 32'(ramREN), 32'd0);
      @(negedge CLK);
      #1;
      chk({tag, "_addr"},  ramaddr, imask[k] ? iaddr : daddr);
      chk({tag, "_iwait"}, 32'(iwait), imask[k] ? 32'd0 : 32'd1);
      chk({tag, "_dwait"}, 32'(dwait), imask[k] ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    nRST = 1'b0; iREN = 0; iaddr = '0; dREN = 0; dWEN = 0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

    // Reset values
    @(negedge CLK); #1;
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_memerr", 32'(memerr), 32'd0);
    @(negedge CLK); nRST = 1'b1;

    // Instruction fetch, ACCESS on second grant cycle
    @(negedge CLK); iREN = 1; iaddr = 32'h0000_0040; ramstate = FREE; #1;
    chk("if_idle_ren", 32'(ramREN), 32'd0);
    @(negedge CLK); ramstate = BUSY; ramload = 32'h8C01_0004; #1;
    chk("if_g1_ren", 32'(ramREN), 32'd1);
    chk("if_g1_addr", ramaddr, 32'h40);
    chk("if_g1_iwait", 32'(iwait), 32'd1);
    chk("if_g1_iload", iload, 32'd0);
    @(negedge CLK); ramstate = ACCESS; #1;
    chk("if_g2_ren", 32'(ramREN), 32'd1);
    chk("if_g2_addr", ramaddr, 32'h40);
    chk("if_g2_iwait", 32'(iwait), 32'd0);
    chk("if_g2_iload", iload, 32'h8C01_0004);
    @(negedge CLK); iREN = 0; ramstate = FREE; #1;
    chk("if_done_ren", 32'(ramREN), 32'd0);

    // dREN and dWEN together: write wins
    @(negedge CLK); dREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; #1;
    chk("wr_idle_wen", 32'(ramWEN), 32'd0);
    @(negedge CLK); ramstate = ACCESS; #1;
    chk("wr_wen", 32'(ramWEN), 32'd1);
    chk("wr_ren", 32'(ramREN), 32'd0);
    chk("wr_addr", ramaddr, 32'h100);
    chk("wr_store", ramstore, 32'hDEAD_BEEF);
    chk("wr_dwait", 32'(dwait), 32'd0);
    chk("wr_iwait", 32'(iwait), 32'd1);
    @(negedge CLK); dREN = 0; dWEN = 0; ramstate = FREE; #1;
    chk("wr_done_wen", 32'(ramWEN), 32'd0);

    // Starvation: D,D,D,D,I,D,D
    @(negedge CLK); iREN = 1; dREN = 1; iaddr = 32'h40; daddr = 32'h200;
    ramload = 32'h1234_5678; ramstate = ACCESS;
    grants(7, 16'h0010, "starve");
    chk("starve_dload", dload, 32'h1234_5678);
    @(negedge CLK); iREN = 0; dREN = 0; ramstate = FREE; #1;
    chk("starve_end_ren", 32'(ramREN), 32'd0);

    // ERROR during DREAD -> ERRWAIT -> retry
    @(negedge CLK); dREN = 1; daddr = 32'h300; #1;
    chk("err_idle_ren", 32'(ramREN), 32'd0);
    @(negedge CLK); ramstate = ERROR; #1;
    chk("err_memerr", 32'(memerr), 32'd1);
    chk("err_dwait", 32'(dwait), 32'd1);
    chk("err_dload", dload, 32'd0);
    @(negedge CLK); ramstate = FREE; #1;
    chk("errw_ren", 32'(ramREN), 32'd0);
    chk("errw_memerr", 32'(memerr), 32'd0);
    chk("errw_dwait", 32'(dwait), 32'd1);
    @(negedge CLK); #1;
    chk("err_idle2_ren", 32'(ramREN), 32'd0);
    @(negedge CLK); ramstate = ACCESS; ramload = 32'h0000_CAFE; #1;
    chk("retry_ren", 32'(ramREN), 32'd1);
    chk("retry_addr", ramaddr, 32'h300);
    chk("retry_dwait", 32'(dwait), 32'd0);
    chk("retry_dload", dload, 32'h0000_CAFE);
    chk("retry_memerr", 32'(memerr), 32'd0);
    @(negedge CLK); dREN = 0; ramstate = FREE;

    // dREN withdrawn mid-DREAD, pending iREN served next
    @(negedge CLK); dREN = 1; iREN = 1; daddr = 32'h400; iaddr = 32'h40; #1;
    chk("wd_idle_ren", 32'(ramREN), 32'd0);
    @(negedge CLK); ramstate = BUSY; #1;
    chk("wd_g_ren", 32'(ramREN), 32'd1);
    chk("wd_g_addr", ramaddr, 32'h400);
    @(negedge CLK); dREN = 0; #1;
    chk("wd_drop_ren", 32'(ramREN), 32'd0);
    chk("wd_drop_dwait", 32'(dwait), 32'd1);
    @(negedge CLK); #1;
    chk("wd_idle2_ren", 32'(ramREN), 32'd0);
    @(negedge CLK); ramstate = ACCESS; ramload = 32'h0BAD_F00D; #1;
    chk("wd_i_addr", ramaddr, 32'h40);
    chk("wd_i_iwait", 32'(iwait), 32'd0);
    chk("wd_i_iload", iload, 32'h0BAD_F00D);
    @(negedge CLK); iREN = 0; ramstate = FREE;

    // Build starve count to 3, then reset mid-DWRITE
    @(negedge CLK); iREN = 1; dREN = 1; daddr = 32'h200; ramstate = ACCESS;
    grants(3, 16'h0000, "pre");
    @(negedge CLK); dREN = 0; dWEN = 1; daddr = 32'h500; dstore = 32'h0000_0011; ramstate = BUSY; #1;
    chk("rdw_idle_wen", 32'(ramWEN), 32'd0);
    @(negedge CLK); #1;
    chk("rdw_wen", 32'(ramWEN), 32'd1);
    chk("rdw_store", ramstore, 32'h11);
    nRST = 1'b0; #1;
    chk("rdw_rst_wen", 32'(ramWEN), 32'd0);
    chk("rdw_rst_dwait", 32'(dwait), 32'd1);
    chk("rdw_rst_store", ramstore, 32'd0);
    chk("rdw_rst_addr", ramaddr, 32'd0);
    @(negedge CLK); #1;
    chk("rdw_hold_iwait", 32'(iwait), 32'd1);
    // After release the counter must be 0: four data grants precede the instruction grant
    @(negedge CLK); nRST = 1'b1; dWEN = 0; dREN = 1; daddr = 32'h200; ramstate = ACCESS;
    grants(5, 16'h0010, "post");
    @(negedge CLK); iREN = 0; dREN = 0; ramstate = FREE; #1;
    chk("final_ren", 32'(ramREN), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
